// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson-code sequence checker.
package johnson_pkg;

  typedef enum logic [1:0] {
    StUnlock,
    StLocked,
    StFault
  } state_e;

  // Width of a sequence index for an N-bit Johnson code (2N positions).
  function automatic int unsigned idx_width(int unsigned n);
    return $clog2(2 * n);
  endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational legality check and sequence-position decode of one Johnson code word.
module johnson_code_decode
  import johnson_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]            code,
  output logic                    legal,
  output logic [idx_width(N)-1:0] index
);

  localparam int unsigned IdxW = idx_width(N);

  logic [N-2:0] edges;
  int unsigned  ones;

  always_comb begin
    // A legal word is a single run of ones and zeros: at most one adjacent-bit transition.
    edges = code[N-1:1] ^ code[N-2:0];
    legal = ((edges & (edges - (N-1)'(1))) == '0);

    ones = 0;
    for (int i = 0; i < N; i++) begin
      ones += 32'(code[i]);
    end
    index = code[N-1] ? IdxW'(2 * N - ones) : IdxW'(ones);
  end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-counter sequence checker: decodes position, tracks lock and counts sequence errors.
// Optional registered one-hot position output when JOHNSON_DECODER_ONEHOT_EN is defined.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned ERR_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N-1:0]            code_in,
  input  logic                    code_valid,
  input  logic                    clr,
  output logic [idx_width(N)-1:0] index,
  output logic                    legal,
  output logic                    locked,
  output logic                    fault,
  output logic [ERR_W-1:0]        err_cnt
`ifdef JOHNSON_DECODER_ONEHOT_EN
  ,
  output logic [2*N-1:0]          onehot
`endif
);

  localparam int unsigned IdxW = idx_width(N);
  localparam int unsigned Len  = 2 * N;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              legal_q, legal_d;
  logic [ERR_W-1:0]  err_q, err_d;

  logic              dec_legal;
  logic [IdxW-1:0]   dec_index;
  logic [IdxW-1:0]   idx_next;
  logic              step_ok;

  johnson_code_decode #(
    .N(N)
  ) u_decode (
    .code  (code_in),
    .legal (dec_legal),
    .index (dec_index)
  );

  // A sample is in step if it repeats or advances the last legal position, wrapping at 2N.
  always_comb begin
    idx_next = (idx_q == IdxW'(Len - 1)) ? '0 : idx_q + IdxW'(1);
    step_ok  = dec_legal && ((dec_index == idx_q) || (dec_index == idx_next));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StUnlock;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = StUnlock;
    end else if (code_valid) begin
      unique case (state_q)
        StUnlock: if (dec_legal) state_d = StLocked;
        StLocked: if (!step_ok) state_d = StFault;
        StFault:  state_d = StFault;
        default:  state_d = StUnlock;
      endcase
    end
  end

  always_comb begin
    idx_d   = idx_q;
    legal_d = legal_q;
    err_d   = err_q;
    if (clr) begin
      err_d = '0;
    end else if (code_valid) begin
      legal_d = dec_legal;
      if (dec_legal) begin
        idx_d = dec_index;
      end
      // Errors are only meaningful once a reference position exists.
      if ((state_q != StUnlock) && !step_ok && (err_q != '1)) begin
        err_d = err_q + ERR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      legal_q <= 1'b0;
      err_q   <= '0;
    end else begin
      idx_q   <= idx_d;
      legal_q <= legal_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    index   = idx_q;
    legal   = legal_q;
    locked  = (state_q == StLocked);
    fault   = (state_q == StFault);
    err_cnt = err_q;
  end

`ifdef JOHNSON_DECODER_ONEHOT_EN
  logic [Len-1:0] onehot_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      onehot_q <= Len'(1);
    end else begin
      onehot_q <= Len'(1) << idx_d;
    end
  end

  assign onehot = onehot_q;
`else
  // Default build exposes only the binary position.
`endif

endmodule

// File: tb/tb_johnson_decoder.sv
// Randomized and directed self-checking bench for johnson_decoder (N=4, ERR_W=8).
module tb_johnson_decoder;

  localparam int Nb  = 4;
  localparam int Len = 2 * Nb;

  logic       clk;
  logic       reset;
  logic [3:0] code_in;
  logic       code_valid;
  logic       clr;
  logic [2:0] index;
  logic       legal;
  logic       locked;
  logic       fault;
  logic [7:0] err_cnt;
`ifdef JOHNSON_DECODER_ONEHOT_EN
  logic [7:0] onehot;
`endif

  johnson_decoder #(
    .N     (4),
    .ERR_W (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .code_in    (code_in),
    .code_valid (code_valid),
    .clr        (clr),
    .index      (index),
    .legal      (legal),
    .locked     (locked),
    .fault      (fault),
    .err_cnt    (err_cnt)
`ifdef JOHNSON_DECODER_ONEHOT_EN
    ,
    .onehot     (onehot)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: sequence table plus plain integer state (0 unlock, 1 locked, 2 fault).
  int seq[Len];
  int m_state = 0;
  int m_idx   = 0;
  int m_legal = 0;
  int m_err   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_idx   = 0;
    m_legal = 0;
    m_err   = 0;
  endtask

  task automatic model_step(input int v, input int code, input int c);
    int pos;
    int ok;
    if (c != 0) begin
      m_state = 0;
      m_err   = 0;
      return;
    end
    if (v == 0) return;
    pos = -1;
    for (int i = 0; i < Len; i++) if (seq[i] == code) pos = i;
    m_legal = (pos >= 0);
    ok = (pos >= 0) && ((pos == m_idx) || (pos == (m_idx + 1) % Len));
    if (m_state == 0) begin
      if (pos >= 0) m_state = 1;
    end else if (ok == 0) begin
      m_state = 2;
      if (m_err < 255) m_err++;
    end
    if (pos >= 0) m_idx = pos;
  endtask

  task automatic step(input int v, input int code, input int c);
    code_valid = v[0];
    code_in    = code[3:0];
    clr        = c[0];
    @(posedge clk);
    model_step(v, code, c);
    #1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("index", int'(index), m_idx);
    chk("legal", int'(legal), m_legal);
    chk("locked", int'(locked), int'(m_state == 1));
    chk("fault", int'(fault), int'(m_state == 2));
    chk("err_cnt", int'(err_cnt), m_err);
`ifdef JOHNSON_DECODER_ONEHOT_EN
    chk("onehot", int'(onehot), 1 << m_idx);
`endif
  end

  initial begin
    int c;
    int r;
    int code;
    c = 0;
    for (int i = 0; i < Len; i++) begin
      seq[i] = c;
      c = ((c << 1) & 15) | ((~(c >> 3)) & 1);
    end

    reset      = 1'b0;
    code_in    = 4'd0;
    code_valid = 1'b0;
    clr        = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_index", int'(index), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err", int'(err_cnt), 0);
    reset = 1'b1;

    // Free-running counter from 0000 for 10 clocks.
    step(1, 4'b0000, 0);
    chk("cnt_first_locked", int'(locked), 1);
    chk("cnt_first_index", int'(index), 0);
    for (int i = 1; i < 10; i++) begin
      step(1, seq[i % Len], 0);
      if (i == 7) chk("cnt_index7", int'(index), 7);
      if (i == 8) chk("cnt_wrap", int'(index), 0);
    end
    chk("cnt_err", int'(err_cnt), 0);

    // Locked at 3, illegal 0101.
    step(1, 4'b0011, 0);
    step(1, 4'b0111, 0);
    step(1, 4'b0101, 0);
    chk("ill_legal", int'(legal), 0);
    chk("ill_fault", int'(fault), 1);
    chk("ill_err", int'(err_cnt), 1);
    chk("ill_index", int'(index), 3);

    // Locked at 2, skip to 1111.
    step(0, 0, 1);
    step(1, 4'b0000, 0);
    step(1, 4'b0001, 0);
    step(1, 4'b0011, 0);
    step(1, 4'b1111, 0);
    chk("skip_fault", int'(fault), 1);
    chk("skip_err", int'(err_cnt), 1);
    chk("skip_index", int'(index), 4);

    // Saturate the error counter, then clear with a concurrent sample.
    repeat (255) step(1, 4'b0101, 0);
    chk("sat_err", int'(err_cnt), 255);
    step(1, 4'b0001, 1);
    chk("clr_locked", int'(locked), 0);
    chk("clr_fault", int'(fault), 0);
    chk("clr_err", int'(err_cnt), 0);
    chk("clr_index", int'(index), 4);

    // Repeated 1110 while locked.
    repeat (3) step(1, 4'b1110, 0);
    chk("hold_locked", int'(locked), 1);
    chk("hold_index", int'(index), 5);
    chk("hold_err", int'(err_cnt), 0);
    step(1, 4'b1100, 0);
    chk("at6_index", int'(index), 6);

    // Asynchronous reset between edges.
    code_valid = 1'b0;
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    chk("areset_index", int'(index), 0);
    chk("areset_locked", int'(locked), 0);
    chk("areset_legal", int'(legal), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1, 4'b0001, 0);
    chk("relock_locked", int'(locked), 1);
    chk("relock_index", int'(index), 1);

    // Randomized traffic biased toward in-step codes.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) code = seq[(m_idx + $urandom_range(0, 2)) % Len];
      else code = $urandom_range(0, 15);
      step(($urandom_range(0, 3) != 0) ? 1 : 0, code, ($urandom_range(0, 29) == 0) ? 1 : 0);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/johnson_decoder.md
JOHNSON_DECODER -- requirements
Module: johnson_decoder

Interface
REQ-001 SHALL have parameter N, default 4, Johnson code width (N >= 2).
REQ-002 SHALL have parameter ERR_W, default 8, error-counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port code_in  input  N  Johnson code sampled from the counter under check.
REQ-006 SHALL have port code_valid  input  1  code_in is sampled only when this is high.
REQ-007 SHALL have port clr  input  1  synchronous clear of FAULT state and the error counter.
REQ-008 SHALL have port index  output  $clog2(2N)  decoded sequence position of the last legal sample.
REQ-009 SHALL have port legal  output  1  last sample was a legal Johnson code.
REQ-010 SHALL have port locked  output  1  FSM is in LOCKED.
REQ-011 SHALL have port fault  output  1  FSM is in FAULT.
REQ-012 SHALL have port err_cnt  output  ERR_W  saturating count of sequence errors.

Function
REQ-013 SHALL use the sequence next = {code[N-2:0], ~code[N-1]}; for N=4: 0000,0001,0011,0111,1111,1110,1100,1000, then 0000.
REQ-014 SHALL classify a code as legal iff it is 0..01..1 or 1..10..0; this gives 2N legal codes.
REQ-015 SHALL decode index = popcount(code) when code[N-1]=0, else 2N - popcount(code).
REQ-016 SHALL register all outputs; a sample taken at edge k is reflected on the outputs after edge k.
REQ-017 SHALL update index only on a legal valid sample; legal SHALL update on every valid sample; all outputs SHALL hold when code_valid=0.
REQ-018 SHALL implement FSM states UNLOCK, LOCKED and FAULT.
REQ-019 UNLOCK: a legal sample SHALL go to LOCKED and capture index; an illegal sample SHALL stay in UNLOCK and SHALL NOT count an error.
REQ-020 LOCKED: a legal sample with index equal to prev or to (prev+1) mod 2N SHALL stay in LOCKED.
REQ-021 LOCKED: any other sample, including an illegal code, SHALL go to FAULT and increment err_cnt.
REQ-022 FAULT: state SHALL be sticky; each illegal or out-of-step sample SHALL increment err_cnt; step checks SHALL use the last legal index.
REQ-023 Wrap-around from 2N-1 to 0 SHALL be treated as a legal step.
REQ-024 err_cnt SHALL saturate at 2^ERR_W - 1.
REQ-025 clr=1 SHALL force UNLOCK and err_cnt=0 at the next edge; a concurrent valid sample SHALL be discarded (clr wins).

Reset
REQ-026 reset=0 SHALL immediately, without a clock, set state=UNLOCK, index=0, legal=0, locked=0, fault=0 and err_cnt=0.
REQ-027 A reset asserted mid-sequence SHALL discard history; relock SHALL require a fresh legal sample after release.

Configuration
REQ-028 With JOHNSON_DECODER_ONEHOT_EN defined, the block SHALL add output onehot  output  2N, with bit[index] set, registered in step with index (reset value 1).
REQ-029 Without JOHNSON_DECODER_ONEHOT_EN, the onehot port and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-030 Package johnson_pkg SHALL hold the FSM state typedef (UNLOCK, LOCKED, FAULT) and a function returning the index width for a given N.
REQ-031 Legality check and index decode SHALL live in the combinational sub-module johnson_code_decode (in: code; out: legal, index).

Verification
REQ-032 Reset release, then a free-running 4-bit counter from 0000 for 10 clocks -> locked=1 from the first sample; index follows 0..7 then 0; err_cnt=0.
REQ-033 Locked at index 3 (0111), inject 0101 -> legal=0, fault=1, err_cnt=1; index stays 3.
REQ-034 Locked at index 2 (0011), inject 1111 (skip to 4) -> fault=1, err_cnt=1, index=4.
REQ-035 In FAULT with err_cnt=255 (ERR_W=8), inject another illegal code -> err_cnt stays 255; then clr=1 with valid=1 -> next cycle state=UNLOCK, err_cnt=0, sample ignored.
REQ-036 Hold code_in=1110 for 3 valid cycles while LOCKED -> stays locked, index=5, no error.
REQ-037 Assert reset between clock edges while LOCKED at index 6 -> all outputs zero before the next edge; after release, first sample 0001 -> locked=1, index=1.
